// File: rtl/divider_arbiter_if.sv
// Requester-side and divider-side bus of divider_arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface divider_arbiter_if #(
   parameter int WIDTH = 10
);
   logic             req0;
   logic [WIDTH-1:0] num0;
   logic [WIDTH-1:0] den0;
   logic             req1;
   logic [WIDTH-1:0] num1;
   logic [WIDTH-1:0] den1;
   logic             ack0;
   logic             ack1;
   logic [WIDTH-1:0] res_quotient;
   logic [WIDTH-1:0] res_remainder;
   logic             res_err;
   logic             busy;
   logic             div_start;
   logic [WIDTH-1:0] div_numerator;
   logic [WIDTH-1:0] div_denominator;
   logic [WIDTH-1:0] div_quotient;
   logic [WIDTH-1:0] div_remainder;
   logic             div_done;

   modport slave (
      input  req0, num0, den0, req1, num1, den1,
      input  div_quotient, div_remainder, div_done,
      output ack0, ack1, res_quotient, res_remainder, res_err, busy,
      output div_start, div_numerator, div_denominator
   );

   modport master (
      output req0, num0, den0, req1, num1, den1,
      output div_quotient, div_remainder, div_done,
      input  ack0, ack1, res_quotient, res_remainder, res_err, busy,
      input  div_start, div_numerator, div_denominator
   );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one integer_divider between two requesters.
// Optional DIVARB_WATCHDOG_EN adds a WAIT-state timeout of WD_CYCLES cycles.
module divider_arbiter #(
   parameter int WIDTH     = 10,
   parameter int WD_CYCLES = 64
) (
   input  logic             Clk,
   input  logic             reset,
   divider_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] START   = 2'd1;
   localparam logic [1:0] WAIT    = 2'd2;
   localparam logic [1:0] RESPOND = 2'd3;

   if (WIDTH < 1) begin : g_bad_width
      $error("divider_arbiter: WIDTH must be at least 1");
   end
   if (WD_CYCLES < 1) begin : g_bad_wd
      $error("divider_arbiter: WD_CYCLES must be at least 1");
   end

   logic [1:0]       state;
   logic             grant_id;
   logic             last_served;
   logic             first_wait;
   logic             ack0;
   logic             ack1;
   logic             div_start;
   logic             res_err;
   logic [WIDTH-1:0] div_numerator;
   logic [WIDTH-1:0] div_denominator;
   logic [WIDTH-1:0] res_quotient;
   logic [WIDTH-1:0] res_remainder;

   logic             any_req;
   logic             pick1;
   logic             done_ok;
   logic             wd_expired;
   logic [WIDTH-1:0] sel_num;
   logic [WIDTH-1:0] sel_den;

   // On a tie the requester that was not served last wins.
   always_comb begin
      any_req = bus.req0 | bus.req1;
      pick1   = bus.req1 & (~bus.req0 | ~last_served);
      sel_num = pick1 ? bus.num1 : bus.num0;
      sel_den = pick1 ? bus.den1 : bus.den0;
   end

   // The divider's done from the previous operation may linger into the first WAIT cycle.
   assign done_ok = bus.div_done & ~first_wait;

`ifdef DIVARB_WATCHDOG_EN
   localparam int WD_W = $clog2(WD_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         wd_cnt <= '0;
      end else if (state == WAIT && !done_ok && !wd_expired) begin
         wd_cnt <= wd_cnt + 1'b1;
      end else begin
         wd_cnt <= '0;
      end
   end

   assign wd_expired = (state == WAIT) && (wd_cnt == WD_W'(WD_CYCLES));
`else
   assign wd_expired = 1'b0;
`endif

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         grant_id        <= 1'b0;
         last_served     <= 1'b1;
         first_wait      <= 1'b0;
         ack0            <= 1'b0;
         ack1            <= 1'b0;
         div_start       <= 1'b0;
         res_err         <= 1'b0;
         div_numerator   <= '0;
         div_denominator <= '0;
         res_quotient    <= '0;
         res_remainder   <= '0;
      end else begin
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         div_start <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_id        <= pick1;
                  last_served     <= pick1;
                  div_numerator   <= sel_num;
                  div_denominator <= sel_den;
                  if (sel_den == '0) begin
                     res_quotient  <= '1;
                     res_remainder <= sel_num;
                     res_err       <= 1'b1;
                     ack0          <= ~pick1;
                     ack1          <= pick1;
                     state         <= RESPOND;
                  end else begin
                     div_start <= 1'b1;
                     state     <= START;
                  end
               end
            end
            START: begin
               first_wait <= 1'b1;
               state      <= WAIT;
            end
            WAIT: begin
               first_wait <= 1'b0;
               if (done_ok) begin
                  res_quotient  <= bus.div_quotient;
                  res_remainder <= bus.div_remainder;
                  res_err       <= 1'b0;
                  ack0          <= ~grant_id;
                  ack1          <= grant_id;
                  state         <= RESPOND;
               end else if (wd_expired) begin
                  res_quotient  <= '1;
                  res_remainder <= '0;
                  res_err       <= 1'b1;
                  ack0          <= ~grant_id;
                  ack1          <= grant_id;
                  state         <= RESPOND;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy            = (state != IDLE);
   assign bus.ack0            = ack0;
   assign bus.ack1            = ack1;
   assign bus.div_start       = div_start;
   assign bus.div_numerator   = div_numerator;
   assign bus.div_denominator = div_denominator;
   assign bus.res_quotient    = res_quotient;
   assign bus.res_remainder   = res_remainder;
   assign bus.res_err         = res_err;

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural integer_divider model.
// Define DIVARB_WATCHDOG_EN for both DUT and bench to cover the watchdog build.
module tb_divider_arbiter;

   localparam int W       = 10;
   localparam int WD      = 64;
   localparam int DIV_LAT = 10;

   logic Clk   = 1'b0;
   logic reset = 1'b0;

   always #5 Clk = ~Clk;

   divider_arbiter_if #(.WIDTH(W)) bus ();

   divider_arbiter #(.WIDTH(W), .WD_CYCLES(WD)) dut (
      .Clk   (Clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Divider model: done rises DIV_LAT cycles after start and stays high
   // until one cycle after the next start.
   int         dcnt;
   logic       dclr;
   logic       hang = 1'b0;
   logic [W-1:0] mq;
   logic [W-1:0] mr;
   int         starts = 0;

   always @(posedge Clk or negedge reset) begin
      if (!reset) begin
         bus.div_done      <= 1'b0;
         bus.div_quotient  <= '0;
         bus.div_remainder <= '0;
         dcnt              <= 0;
         dclr              <= 1'b0;
         mq                <= '0;
         mr                <= '0;
      end else begin
         if (dclr) begin
            bus.div_done <= 1'b0;
            dclr         <= 1'b0;
         end
         if (dcnt == 1) begin
            bus.div_done      <= 1'b1;
            bus.div_quotient  <= mq;
            bus.div_remainder <= mr;
         end
         if (dcnt > 0) dcnt <= dcnt - 1;
         if (bus.div_start) begin
            dclr <= 1'b1;
            dcnt <= hang ? 0 : DIV_LAT;
            if (bus.div_denominator != '0) begin
               mq <= bus.div_numerator / bus.div_denominator;
               mr <= bus.div_numerator % bus.div_denominator;
            end
         end
      end
   end

   always @(posedge Clk) begin
      if (bus.div_start) starts <= starts + 1;
   end

   // Ack log: {ack1,ack0} and the result bus at every acknowledge.
   int           n_acks = 0;
   logic [1:0]   log_g [64];
   logic [W-1:0] log_q [64];
   logic [W-1:0] log_r [64];
   logic         log_e [64];

   always @(negedge Clk) begin
      if (bus.ack0 || bus.ack1) begin
         if (n_acks < 64) begin
            log_g[n_acks] <= {bus.ack1, bus.ack0};
            log_q[n_acks] <= bus.res_quotient;
            log_r[n_acks] <= bus.res_remainder;
            log_e[n_acks] <= bus.res_err;
         end
         n_acks <= n_acks + 1;
      end
   end

   task automatic requester(input bit id, input logic [W-1:0] n, input logic [W-1:0] d,
                            input int budget, output bit ok, output int lat);
      ok  = 1'b0;
      lat = 0;
      if (!id) begin
         bus.num0 = n; bus.den0 = d; bus.req0 = 1'b1;
      end else begin
         bus.num1 = n; bus.den1 = d; bus.req1 = 1'b1;
      end
      while (!ok && lat < budget) begin
         @(negedge Clk);
         lat++;
         if (id ? bus.ack1 : bus.ack0) ok = 1'b1;
      end
      if (!id) bus.req0 = 1'b0;
      else     bus.req1 = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge Clk);
      @(negedge Clk);
      n_checks++;
      if ({bus.ack0, bus.ack1, bus.res_quotient, bus.res_remainder, bus.res_err, bus.busy,
           bus.div_start, bus.div_numerator, bus.div_denominator} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ack0=%b ack1=%b q=%0d r=%0d err=%b busy=%b start=%b num=%0d den=%0d, expected all 0",
                  bus.ack0, bus.ack1, bus.res_quotient, bus.res_remainder, bus.res_err, bus.busy,
                  bus.div_start, bus.div_numerator, bus.div_denominator);
      end
      reset = 1'b1;
      @(negedge Clk);
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
      end
   endtask

   task automatic test_tie();
      bit ok0, ok1;
      int l0, l1, base_a, base_s;
      @(negedge Clk);
      base_a = n_acks;
      base_s = starts;
      fork
         requester(1'b0, 10'd100, 10'd7, 100, ok0, l0);
         requester(1'b1, 10'd50,  10'd5, 100, ok1, l1);
      join
      #1;
      n_checks++;
      if ({ok0, ok1} !== 2'b11) begin
         n_fail++;
         $display("FAIL tie_acks_seen: got ok0=%b ok1=%b expected 1 1", ok0, ok1);
      end
      n_checks++;
      if (n_acks - base_a !== 2) begin
         n_fail++;
         $display("FAIL tie_ack_count: got %0d expected 2", n_acks - base_a);
      end
      n_checks++;
      if ({log_g[base_a], log_q[base_a], log_r[base_a], log_e[base_a]} !== {2'b01, 10'd14, 10'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL tie_first: got grant=%b q=%0d r=%0d err=%b expected 01 14 2 0",
                  log_g[base_a], log_q[base_a], log_r[base_a], log_e[base_a]);
      end
      n_checks++;
      if ({log_g[base_a+1], log_q[base_a+1], log_r[base_a+1], log_e[base_a+1]} !== {2'b10, 10'd10, 10'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL tie_second: got grant=%b q=%0d r=%0d err=%b expected 10 10 0 0",
                  log_g[base_a+1], log_q[base_a+1], log_r[base_a+1], log_e[base_a+1]);
      end
      n_checks++;
      if (starts - base_s !== 2) begin
         n_fail++;
         $display("FAIL tie_starts: got %0d expected 2", starts - base_s);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] n0 [3] = '{10'd20, 10'd99, 10'd7};
      logic [W-1:0] d0 [3] = '{10'd3,  10'd9,  10'd8};
      logic [W-1:0] n1 [3] = '{10'd1000, 10'd55, 10'd1023};
      logic [W-1:0] d1 [3] = '{10'd10,   10'd6,  10'd2};
      logic [W-1:0] eq [6] = '{10'd6, 10'd100, 10'd11, 10'd9, 10'd0, 10'd511};
      logic [W-1:0] er [6] = '{10'd2, 10'd0,   10'd0,  10'd1, 10'd7, 10'd1};
      logic [1:0]   exp_g;
      int base_a;
      @(negedge Clk);
      base_a = n_acks;
      fork
         begin
            bit ok; int lat;
            for (int i = 0; i < 3; i++) requester(1'b0, n0[i], d0[i], 100, ok, lat);
         end
         begin
            bit ok; int lat;
            for (int j = 0; j < 3; j++) requester(1'b1, n1[j], d1[j], 100, ok, lat);
         end
      join
      #1;
      n_checks++;
      if (n_acks - base_a !== 6) begin
         n_fail++;
         $display("FAIL b2b_ack_count: got %0d expected 6", n_acks - base_a);
      end
      for (int k = 0; k < 6; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         n_checks++;
         if ({log_g[base_a+k], log_q[base_a+k], log_r[base_a+k], log_e[base_a+k]} !== {exp_g, eq[k], er[k], 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_txn%0d: got grant=%b q=%0d r=%0d err=%b expected %b %0d %0d 0",
                     k, log_g[base_a+k], log_q[base_a+k], log_r[base_a+k], log_e[base_a+k], exp_g, eq[k], er[k]);
         end
      end
   endtask

   task automatic test_single_req0();
      bit ok; int lat, base_a, base_s;
      @(negedge Clk);
      base_a = n_acks;
      base_s = starts;
      requester(1'b0, 10'd25, 10'd4, 100, ok, lat);
      n_checks++;
      if (ok !== 1'b1 || lat !== DIV_LAT + 3) begin
         n_fail++;
         $display("FAIL single_latency: got ok=%b lat=%0d expected 1 %0d", ok, lat, DIV_LAT + 3);
      end
      n_checks++;
      if ({bus.res_quotient, bus.res_remainder, bus.res_err} !== {10'd6, 10'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL single_result: got q=%0d r=%0d err=%b expected 6 1 0",
                  bus.res_quotient, bus.res_remainder, bus.res_err);
      end
      @(negedge Clk);
      n_checks++;
      if ({bus.ack0, bus.ack1, bus.res_quotient, bus.res_remainder} !== {1'b0, 1'b0, 10'd6, 10'd1}) begin
         n_fail++;
         $display("FAIL single_pulse_hold: got ack0=%b ack1=%b q=%0d r=%0d expected 0 0 6 1",
                  bus.ack0, bus.ack1, bus.res_quotient, bus.res_remainder);
      end
      #1;
      n_checks++;
      if (n_acks - base_a !== 1 || log_g[base_a] !== 2'b01 || starts - base_s !== 1) begin
         n_fail++;
         $display("FAIL single_counts: got acks=%0d grant=%b starts=%0d expected 1 01 1",
                  n_acks - base_a, log_g[base_a], starts - base_s);
      end
   endtask

   task automatic test_div_by_zero();
      bit ok; int lat, base_a, base_s;
      @(negedge Clk);
      base_a = n_acks;
      base_s = starts;
      requester(1'b1, 10'd37, 10'd0, 20, ok, lat);
      n_checks++;
      if (ok !== 1'b1 || lat !== 1) begin
         n_fail++;
         $display("FAIL dz_latency: got ok=%b lat=%0d expected 1 1", ok, lat);
      end
      n_checks++;
      if ({bus.res_quotient, bus.res_remainder, bus.res_err} !== {10'd1023, 10'd37, 1'b1}) begin
         n_fail++;
         $display("FAIL dz_result: got q=%0d r=%0d err=%b expected 1023 37 1",
                  bus.res_quotient, bus.res_remainder, bus.res_err);
      end
      @(negedge Clk);
      n_checks++;
      if ({bus.ack1, bus.res_quotient, bus.res_err} !== {1'b0, 10'd1023, 1'b1}) begin
         n_fail++;
         $display("FAIL dz_pulse_hold: got ack1=%b q=%0d err=%b expected 0 1023 1",
                  bus.ack1, bus.res_quotient, bus.res_err);
      end
      #1;
      n_checks++;
      if (n_acks - base_a !== 1 || log_g[base_a] !== 2'b10 || starts - base_s !== 0) begin
         n_fail++;
         $display("FAIL dz_counts: got acks=%0d grant=%b starts=%0d expected 1 10 0",
                  n_acks - base_a, log_g[base_a], starts - base_s);
      end
   endtask

   task automatic test_reset_mid_wait();
      bit ok; int lat;
      @(negedge Clk);
      bus.num0 = 10'd50;
      bus.den0 = 10'd5;
      bus.req0 = 1'b1;
      repeat (4) @(negedge Clk);
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_busy_before: got %b expected 1", bus.busy);
      end
      reset    = 1'b0;
      bus.req0 = 1'b0;
      #1;
      n_checks++;
      if ({bus.ack0, bus.ack1, bus.res_quotient, bus.res_remainder, bus.res_err, bus.busy,
           bus.div_start, bus.div_numerator, bus.div_denominator} !== '0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got ack0=%b ack1=%b q=%0d r=%0d err=%b busy=%b start=%b num=%0d den=%0d, expected all 0",
                  bus.ack0, bus.ack1, bus.res_quotient, bus.res_remainder, bus.res_err, bus.busy,
                  bus.div_start, bus.div_numerator, bus.div_denominator);
      end
      @(negedge Clk);
      reset = 1'b1;
      requester(1'b0, 10'd9, 10'd3, 100, ok, lat);
      n_checks++;
      if ({ok, bus.res_quotient, bus.res_remainder, bus.res_err} !== {1'b1, 10'd3, 10'd0, 1'b0} || lat !== DIV_LAT + 3) begin
         n_fail++;
         $display("FAIL midrst_after: got ok=%b q=%0d r=%0d err=%b lat=%0d expected 1 3 0 0 %0d",
                  ok, bus.res_quotient, bus.res_remainder, bus.res_err, lat, DIV_LAT + 3);
      end
   endtask

   task automatic test_watchdog();
      bit ok; int lat, base_a;
      @(negedge Clk);
      hang   = 1'b1;
      base_a = n_acks;
`ifdef DIVARB_WATCHDOG_EN
      requester(1'b0, 10'd50, 10'd5, 2 * WD + 10, ok, lat);
      n_checks++;
      if (ok !== 1'b1 || lat !== WD + 3) begin
         n_fail++;
         $display("FAIL wd_latency: got ok=%b lat=%0d expected 1 %0d", ok, lat, WD + 3);
      end
      n_checks++;
      if ({bus.res_quotient, bus.res_remainder, bus.res_err} !== {10'd1023, 10'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL wd_result: got q=%0d r=%0d err=%b expected 1023 0 1",
                  bus.res_quotient, bus.res_remainder, bus.res_err);
      end
`else
      requester(1'b0, 10'd50, 10'd5, 2 * WD, ok, lat);
      #1;
      n_checks++;
      if ({ok, bus.busy} !== 2'b01 || n_acks - base_a !== 0) begin
         n_fail++;
         $display("FAIL nowd_stuck: got ok=%b busy=%b acks=%0d expected 0 1 0",
                  ok, bus.busy, n_acks - base_a);
      end
      reset = 1'b0;
      @(negedge Clk);
      reset = 1'b1;
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL nowd_recover: got busy=%b expected 0", bus.busy);
      end
`endif
      hang = 1'b0;
   endtask

   initial begin
      bus.req0 = 1'b0; bus.num0 = '0; bus.den0 = '0;
      bus.req1 = 1'b0; bus.num1 = '0; bus.den1 = '0;
      test_reset();
      test_tie();
      test_back_to_back();
      test_single_req0();
      test_div_by_zero();
      test_reset_mid_wait();
      test_watchdog();
      @(negedge Clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
Shares the single integer_divider instance between two requesters, e.g. the calculator FSM and a future display/BCD path. Arbitrates round-robin, registers the operands and sequences the divider's start/done handshake. Short-circuits divide-by-zero and returns quotient/remainder to the granted requester with a one-cycle acknowledge. Sits between the requesters and integer_divider, on the same clock.

Parameters:
WIDTH, 10, operand/result width; must match the integer_divider instance.
WD_CYCLES, 64, watchdog limit in WAIT (cycles), used only with the optional feature.

Ports:
Clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req0  in  1  requester 0 request; held high, operands stable, until ack0
num0  in  WIDTH  requester 0 numerator
den0  in  WIDTH  requester 0 denominator
req1  in  1  requester 1 request
num1  in  WIDTH  requester 1 numerator
den1  in  WIDTH  requester 1 denominator
ack0  out  1  one-cycle pulse; result bus valid for requester 0
ack1  out  1  one-cycle pulse; result bus valid for requester 1
res_quotient  out  WIDTH  registered quotient
res_remainder  out  WIDTH  registered remainder
res_err  out  1  divide-by-zero (or watchdog) error flag, valid with ack
busy  out  1  high in any state other than IDLE
div_start  out  1  one-cycle start pulse to the divider
div_numerator  out  WIDTH  registered numerator to the divider
div_denominator  out  WIDTH  registered denominator to the divider
div_quotient  in  WIDTH  divider quotient
div_remainder  in  WIDTH  divider remainder
div_done  in  1  divider completion

Behaviour:
- Reset (async, reset=0): state IDLE, all outputs 0, last_served=1, so requester 0 wins the first tie.
- States: IDLE, START, WAIT, RESPOND.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester that is not last_served.
  - On grant: latch the grant id; latch num/den into div_numerator/div_denominator; update last_served.
  - If latched den==0: go to RESPOND with quotient={WIDTH{1}}, remainder=num, err=1. The divider is never started.
  - Otherwise go to START.
- START: div_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Ignore div_done in the first WAIT cycle, because the divider's done from the previous operation may still be high.
  - On the first qualifying div_done=1: capture div_quotient/div_remainder, set err=0, go to RESPOND.
- RESPOND: ack of the granted id=1 for one cycle; the other ack stays 0. Then go to IDLE.
- Result bus: res_quotient/res_remainder/res_err hold their value until the next RESPOND.
- Latency:
  - Divide-by-zero: request high in IDLE cycle T gives ack in cycle T+1.
  - Normal: ack in the cycle after div_done is sampled; minimum T+4.
- Requester rule: drop req on the same edge at which it samples ack=1. The arbiter re-samples requests only in IDLE, so a held-over req would be treated as a new request.
- Operands are sampled once at grant; later changes to num/den are ignored.
- Requests that arrive while busy wait and are never lost. With both requesters continuously active, grants strictly alternate 0,1,0,1.
- Reset mid-operation returns to IDLE immediately with ack0/ack1/div_start=0. The divider is reset by the same reset, so no stale done is consumed.

Optional Feature:
DIVARB_WATCHDOG_EN
- Defined:
  - A counter runs in WAIT.
  - If div_done is not seen within WD_CYCLES cycles of entering WAIT, go to RESPOND with quotient={WIDTH{1}}, remainder=0, err=1.
  - The counter clears on leaving WAIT.
- Not defined: no counter exists, WD_CYCLES is unused, and WAIT lasts until div_done.

Test Plan:
- req0, num0=25, den0=4, divider model done after 10 cycles -> one ack0 pulse, quotient=6, remainder=1, err=0; ack1 never asserted.
- req0 and req1 high in the same cycle after reset (100/7, 50/5) -> served 0 then 1; results 14r2 (ack0) then 10r0 (ack1); exactly one div_start per request.
- Both requesters re-requesting continuously for 6 transactions -> grants alternate 0,1,0,1,0,1 with no repeats.
- req1, num1=37, den1=0 -> ack1 on the cycle after the request, quotient=1023, remainder=37, err=1, no div_start.
- reset pulled low during WAIT, then released -> all outputs 0, busy=0; a new req0 of 9/3 returns 3r0.
- With DIVARB_WATCHDOG_EN, div_done held low -> ack WD_CYCLES+1 cycles after entering WAIT, err=1, quotient=1023; without the macro no ack occurs within 2*WD_CYCLES.
